// File: rtl/midi_uart_tx_pkg.sv
// Shared types and constants for the MIDI OUT/THRU serializer.
package midi_uart_tx_pkg;

  localparam int unsigned SYSTEM_CLOCK = 50_000_000;
  localparam int unsigned MIDI_BAUD    = 31_250;
  localparam int unsigned BYTE_WIDTH   = 8;
  localparam int unsigned BAUD_CNT_W   = 11;
  localparam int unsigned BIT_CNT_W    = 3;

  typedef logic [BYTE_WIDTH-1:0] byte_t;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } midi_tx_state_t;

  // Channel voice/mode status bytes 0x80-0xEF.
  function automatic logic is_channel_status(byte_t b);
    return b[7] && (b[7:4] != 4'hF);
  endfunction

  // System common / sysex bytes 0xF0-0xF7.
  function automatic logic is_system_common(byte_t b);
    return b[7:3] == 5'b11110;
  endfunction

endpackage

// File: rtl/midi_uart_tx_byte_fifo.sv
// Small power-of-two byte FIFO with registered ready (not full) and empty flags.
module midi_uart_tx_byte_fifo
  import midi_uart_tx_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic  clock,
  input  logic  reset,
  input  logic  push,
  input  byte_t wdata,
  input  logic  pop,
  output byte_t head_c,
  output logic  ready,
  output logic  empty,
  output logic  empty_next_c
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $fatal(1, "byte fifo DEPTH must be a power of two >= 2");
  end

  byte_t         mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          do_push;
  logic          do_pop;

  // Occupancy update; simultaneous push and pop leave it unchanged.
  always_comb begin
    do_push    = push && ready;
    do_pop     = pop && !empty;
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
    empty_next_c = (count_next == '0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ready  <= 1'b1;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
      ready <= (count_next != CW'(DEPTH));
      empty <= empty_next_c;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign head_c = mem[rd_ptr];

endmodule

// File: rtl/midi_uart_tx.sv
// MIDI OUT/THRU 8N1 serializer fed from a byte FIFO.
// Define MIDI_RUNNING_STATUS_EN to drop repeated channel status bytes on dequeue.
module midi_uart_tx
  import midi_uart_tx_pkg::*;
#(
  parameter int unsigned CLOCK_HZ   = SYSTEM_CLOCK,
  parameter int unsigned BAUD       = MIDI_BAUD,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic  clock,
  input  logic  reset,
  input  byte_t data,
  input  logic  data_valid,
  output logic  data_ready,
  output logic  tx,
  output logic  busy
);

  localparam int unsigned CLKS_PER_BIT = CLOCK_HZ / BAUD;

  if (CLOCK_HZ % BAUD != 0) begin : g_bad_ratio
    $fatal(1, "CLOCK_HZ / BAUD must be an integer");
  end
  if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > (1 << BAUD_CNT_W)) begin : g_bad_range
    $fatal(1, "CLKS_PER_BIT out of baud counter range");
  end

  midi_tx_state_t        state;
  midi_tx_state_t        state_next;
  byte_t                 shift;
  byte_t                 shift_next;
  logic [BAUD_CNT_W-1:0] baud_cnt;
  logic [BAUD_CNT_W-1:0] baud_next;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic [BIT_CNT_W-1:0]  bit_next;
  logic                  tx_next;
  logic                  busy_next;
  logic                  bit_end;
  logic                  load;
  logic                  pop;
  logic                  send;

  byte_t fifo_head;
  logic  fifo_ready;
  logic  fifo_empty;
  logic  fifo_empty_next;

  midi_uart_tx_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock        (clock),
    .reset        (reset),
    .push         (data_valid),
    .wdata        (data),
    .pop          (pop),
    .head_c       (fifo_head),
    .ready        (fifo_ready),
    .empty        (fifo_empty),
    .empty_next_c (fifo_empty_next)
  );

  assign data_ready = fifo_ready;

`ifdef MIDI_RUNNING_STATUS_EN
  byte_t last_status;
  byte_t last_status_next;
  logic  last_valid;
  logic  last_valid_next;

  // Running-status filter: a repeat of the live channel status is not sent.
  always_comb begin
    send             = !(is_channel_status(fifo_head) && last_valid &&
                         (fifo_head == last_status));
    last_status_next = last_status;
    last_valid_next  = last_valid;
    if (load && send) begin
      if (is_channel_status(fifo_head)) begin
        last_status_next = fifo_head;
        last_valid_next  = 1'b1;
      end else if (is_system_common(fifo_head)) begin
        last_valid_next  = 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_status <= '0;
      last_valid  <= 1'b0;
    end else begin
      last_status <= last_status_next;
      last_valid  <= last_valid_next;
    end
  end
`else
  assign send = 1'b1;
`endif

  // State and datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      shift    <= '0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
    end else begin
      state    <= state_next;
      shift    <= shift_next;
      baud_cnt <= baud_next;
      bit_cnt  <= bit_next;
      tx       <= tx_next;
      busy     <= busy_next;
    end
  end

  // Next-state, counters and FIFO dequeue.
  always_comb begin
    state_next = state;
    shift_next = shift;
    baud_next  = baud_cnt;
    bit_next   = bit_cnt;
    load       = 1'b0;
    pop        = 1'b0;
    bit_end    = (baud_cnt == BAUD_CNT_W'(CLKS_PER_BIT - 1));

    case (state)
      IDLE: load = !fifo_empty;
      START: begin
        if (bit_end) begin
          baud_next  = '0;
          state_next = DATA;
        end else begin
          baud_next  = baud_cnt + BAUD_CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_next  = '0;
          shift_next = shift >> 1;
          if (bit_cnt == BIT_CNT_W'(7)) begin
            bit_next   = '0;
            state_next = STOP;
          end else begin
            bit_next   = bit_cnt + BIT_CNT_W'(1);
          end
        end else begin
          baud_next = baud_cnt + BAUD_CNT_W'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_next  = '0;
          state_next = IDLE;
          load       = !fifo_empty;
        end else begin
          baud_next  = baud_cnt + BAUD_CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase

    // A popped byte either starts a frame or is discarded back to IDLE.
    if (load) begin
      pop = 1'b1;
      if (send) begin
        state_next = START;
        shift_next = fifo_head;
        baud_next  = '0;
        bit_next   = '0;
      end else begin
        state_next = IDLE;
      end
    end
  end

  // Output decode from next state so tx and busy come straight from flops.
  always_comb begin
    tx_next = 1'b1;
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      default: tx_next = 1'b1;
    endcase
    busy_next = (state_next != IDLE) || !fifo_empty_next;
  end

endmodule

// File: tb/tb_midi_uart_tx.sv
// Scoreboard bench for midi_uart_tx: stimulus queues expected frames, a serial monitor decodes tx.
module tb_midi_uart_tx;

  localparam int CPB   = 16;
  localparam int FRAME = 10 * CPB;

`ifdef MIDI_RUNNING_STATUS_EN
  localparam bit RS_EN = 1'b1;
`else
  localparam bit RS_EN = 1'b0;
`endif

  typedef struct {
    logic [7:0] b;
    bit         contig;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data = 8'h00;
  logic       data_valid = 1'b0;
  logic       data_ready;
  logic       tx;
  logic       busy;

  midi_uart_tx #(
    .CLOCK_HZ   (500_000),
    .BAUD       (31_250),
    .FIFO_DEPTH (4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .data       (data),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .tx         (tx),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Serial monitor: samples each bit at mid-cell, compares against the scoreboard.
  bit         mon_busy = 1'b0;
  int         mon_cnt = 0;
  int         mon_start = 0;
  int         prev_start = -100000;
  logic [7:0] rx = 8'h00;
  exp_t       e;

  always @(negedge clock) begin
    if (!mon_busy) begin
      if (tx === 1'b0) begin
        mon_busy  = 1'b1;
        mon_cnt   = 0;
        mon_start = cyc;
      end
    end else begin
      mon_cnt++;
      if (busy !== 1'b1) begin
        mon_busy = 1'b0;
      end else if (mon_cnt % CPB == CPB / 2) begin
        int bi;
        bi = mon_cnt / CPB;
        if (bi == 0) begin
          chk("start_bit", int'(tx), 0);
        end else if (bi <= 8) begin
          rx[bi-1] = tx;
        end else begin
          chk("stop_bit", int'(tx), 1);
          if (sb.size() == 0) begin
            chk("unexpected_frame", int'(rx), -1);
          end else begin
            e = sb.pop_front();
            chk("frame_byte", int'(rx), int'(e.b));
            if (e.contig) chk("start_spacing", mon_start - prev_start, FRAME);
          end
          prev_start = mon_start;
          mon_busy   = 1'b0;
        end
      end
    end
  end

  // Present a byte from a negedge and hold it until accepted; acc = accepting edge count.
  task automatic push(input logic [7:0] b, input bit exp_tx, input bit contig, output int acc);
    int g;
    g = 0;
    @(negedge clock);
    data       = b;
    data_valid = 1'b1;
    while (!data_ready && g < 8 * FRAME) begin
      @(negedge clock);
      g++;
    end
    chk("push_ready", int'(data_ready), 1);
    acc = cyc + 1;
    @(posedge clock);
    if (exp_tx) sb.push_back('{b: b, contig: contig});
  endtask

  task automatic release_valid();
    @(negedge clock);
    data_valid = 1'b0;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clock);
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    @(negedge clock);
    while ((busy || mon_busy) && g < 8 * FRAME) begin
      @(negedge clock);
      g++;
    end
    chk("idle_reached", int'(!busy && !mon_busy), 1);
    chk("scoreboard_drained", sb.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset      = 1'b1;
    data_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    sb.delete();
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int         acc;
    int         acc1;
    int         acc6;
    int         lows;
    logic [7:0] seq1 [7];
    logic [7:0] seq2 [8];
    seq1 = '{8'h90, 8'h3C, 8'h64, 8'hF8, 8'h90, 8'h3E, 8'h64};
    seq2 = '{8'h90, 8'h3C, 8'h64, 8'hF8, 8'hF0, 8'h90, 8'h3E, 8'h64};

    repeat (3) @(negedge clock);
    reset = 1'b0;
    chk("reset_tx", int'(tx), 1);
    chk("reset_busy", int'(busy), 0);
    chk("reset_ready", int'(data_ready), 1);

    // Single 0x90: latency, bit pattern via monitor, busy fall time.
    push(8'h90, 1'b1, 1'b0, acc);
    release_valid();
    chk("busy_n1", int'(busy), 1);
    chk("tx_n1", int'(tx), 1);
    @(negedge clock);
    chk("tx_n2_start", int'(tx), 0);
    wait_until(acc + FRAME);
    chk("busy_last_stop", int'(busy), 1);
    @(negedge clock);
    chk("busy_fall", int'(busy), 0);
    wait_idle();

    // Burst of three on consecutive cycles: contiguous frames.
    do_reset();
    push(8'h90, 1'b1, 1'b0, acc);
    push(8'h3C, 1'b1, 1'b1, acc);
    push(8'h64, 1'b1, 1'b1, acc);
    release_valid();
    wait_idle();

    // Six bytes into depth 4: backpressure after byte 5, byte 6 after first frame.
    do_reset();
    push(8'h11, 1'b1, 1'b0, acc1);
    push(8'h22, 1'b1, 1'b1, acc);
    push(8'h33, 1'b1, 1'b1, acc);
    push(8'h44, 1'b1, 1'b1, acc);
    push(8'h55, 1'b1, 1'b1, acc);
    @(negedge clock);
    data_valid = 1'b0;
    chk("ready_low_full", int'(data_ready), 0);
    push(8'h66, 1'b1, 1'b1, acc6);
    release_valid();
    chk("byte6_accept_cycle", acc6, acc1 + FRAME + 2);
    wait_idle();

    // Running-status sequence; the repeated 0x90 drops only when the feature is built.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      push(seq1[i], !(RS_EN && i == 4), (i != 0) && !(RS_EN && i == 5), acc);
    end
    release_valid();
    wait_idle();

    // 0xF0 cancels running status, so every byte is sent.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      push(seq2[i], 1'b1, i != 0, acc);
    end
    release_valid();
    wait_idle();

    // Reset in the middle of data bit 4 with two bytes queued.
    do_reset();
    push(8'hA5, 1'b0, 1'b0, acc1);
    push(8'h5A, 1'b0, 1'b0, acc);
    push(8'h3C, 1'b0, 1'b0, acc);
    release_valid();
    wait_until(acc1 + 1 + 5 * CPB + CPB / 2);
    chk("busy_before_reset", int'(busy), 1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("rst_mid_tx", int'(tx), 1);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_ready", int'(data_ready), 1);
    lows = 0;
    repeat (3 * FRAME) begin
      @(negedge clock);
      if (tx !== 1'b1) lows++;
    end
    chk("tx_quiet_after_reset", lows, 0);
    chk("busy_quiet_after_reset", int'(busy), 0);

    // Twenty bytes with valid held through backpressure.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      push(8'(i * 5 + 1), 1'b1, i != 0, acc);
    end
    release_valid();
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/midi_uart_tx.md
# midi_uart_tx

MIDI OUT / THRU serializer for the synthesizer. It accepts MIDI bytes from the control side over a valid/ready handshake and buffers them in a small FIFO. Each byte goes out as an 8N1 UART frame at 31 250 baud on a single output pin, derived from the 50 MHz system clock. This is the transmit counterpart of the MIDI input path: a byte stream that the receiver would decode re-emerges here as a bit-exact serial stream.

## Interface
- CLOCK_HZ, CONFIG::SYSTEM_CLOCK (50 000 000): system clock frequency.
- BAUD, CONFIG::MIDI_BAUD (31 250): bit rate.
- FIFO_DEPTH, 4: byte buffer entries; power of two, ≥2.
- clock  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- data  in  CONFIG::BYTE_WIDTH (8)  MIDI byte to send.
- data_valid  in  1  data is presented.
- data_ready  out  1  FIFO not full; a byte is accepted on any edge where data_valid && data_ready.
- tx  out  1  serial line, idle high.
- busy  out  1  frame in progress or FIFO non-empty.

## Operation
- CLKS_PER_BIT = CLOCK_HZ / BAUD = 1600. Checked at elaboration: non-integer ratio is a fatal error.
- Frame format: start bit (0), data[0]..data[7] LSB first, stop bit (1). 10 bits = 16 000 cycles.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If FIFO is non-empty, pop one byte into the shift register and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: tx=shift[0]. Shift right every CLKS_PER_BIT cycles. A 3-bit bit counter runs 0..7; after bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. On the last stop cycle, if the FIFO is non-empty, pop and go straight to START (no idle gap); otherwise go to IDLE.
- Baud counter is 11 bits wide, counts 0..CLKS_PER_BIT-1, and reloads at each bit boundary.
- data_ready = !fifo_full, a registered flag. A push is ignored when full.
- A push and a pop in the same cycle are both honored; occupancy is unchanged.
- tx is driven directly from a flop (glitch-free).
- Reset mid-frame: tx=1 on the edge after reset is sampled. The FIFO is emptied, the FSM goes to IDLE, and the partial frame is abandoned.

## Timing
- Reset values: tx=1, busy=0, data_ready=1. FIFO is empty, the FSM is in IDLE, and the running-status register (if built) is invalid.
- Latency: a byte is accepted at edge N with the FSM IDLE and the FIFO empty.
  - Edge N+1: the FIFO is non-empty and busy=1.
  - Edge N+2: the pop registers START, and tx=0 from then on.
- Back-to-back frames: the falling edge of the next start bit is exactly 16 000 cycles after the previous one.
- busy falls at the edge that leaves STOP with the FIFO empty.
- data_ready deasserts at the edge where occupancy reaches FIFO_DEPTH. It reasserts on the edge after the pop.

## Configuration
- MIDI_RUNNING_STATUS_EN defined: running-status compression on dequeue.
  - Keep last_status (8 bits plus a valid flag).
  - A popped byte in 0x80–0xEF that equals a valid last_status is discarded. No frame is sent; the next FIFO entry is considered on the following cycle.
  - Any other 0x80–0xEF byte is sent and becomes last_status.
  - 0xF0–0xF7 is sent and invalidates last_status.
  - 0xF8–0xFF (realtime) is sent and leaves last_status unchanged.
  - Data bytes 0x00–0x7F are always sent.
- Not defined: every accepted byte is transmitted verbatim; the last_status logic is absent.

## Structure
- CONFIG package additions:
  - MIDI_BAUD = 31250.
  - typedef logic [BYTE_WIDTH-1:0] byte_t.
  - enum midi_tx_state_t {IDLE, START, DATA, STOP}.
- One sub-module: byte_fifo (parameterized depth, registered full/empty, same clock and reset).
- The FSM, shift register, baud and bit counters, and the running-status logic live in midi_uart_tx.

## Test plan
- Single 0x90 after reset:
  - tx low from edge N+2.
  - Then 1600-cycle bits 0,0,0,0,1,0,0,1, then stop bit 1.
  - busy falls after 16 000 cycles plus latency.
- Burst 0x90,0x3C,0x64 pushed on consecutive cycles: three contiguous frames of 48 000 cycles with no idle cycles, and each decoded byte matches.
- Push 6 bytes on consecutive cycles with depth 4:
  - data_ready is low after byte 5 (1 in shift, 4 in FIFO).
  - Byte 6 is accepted only after the first frame ends.
  - All 6 bytes appear in order.
- With MIDI_RUNNING_STATUS_EN:
  - Input 0x90,0x3C,0x64,0xF8,0x90,0x3E,0x64 sends 6 frames (the second 0x90 is dropped).
  - Inserting 0xF0 before the second 0x90 sends all bytes.
  - With the macro undefined, all 7 bytes are sent.
- Reset asserted for 1 cycle in the middle of bit 4 with 2 bytes queued:
  - tx=1, busy=0 and data_ready=1 on the next edge.
  - No further frames until a new push.
- Push held with data_valid while full: no byte is lost or duplicated across 20 bytes; a bench scoreboard compares the serial decode against the input.
